// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer FSM encoding and reset PC.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [0:15] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer and its memory, decoder and
// execute neighbours.
interface pc_sequencer_if;

    logic [0:15] pc;
    logic        fetch_req;
    logic        fetch_ack;
    logic [0:15] fetch_instr;
    logic [0:15] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        done;
    logic        j_valid;
    logic        cond;
    logic [0:15] j_target;
    logic        halt;
    logic        halted;
    logic [0:15] jump_count;

    modport master (
        output pc, fetch_req, instr, instr_valid, halted, jump_count,
        input  fetch_ack, fetch_instr, instr_ready, done, j_valid,
               cond, j_target, halt
    );

    modport slave (
        input  pc, fetch_req, instr, instr_valid, halted, jump_count,
        output fetch_ack, fetch_instr, instr_ready, done, j_valid,
               cond, j_target, halt
    );

endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch, issue, wait for completion, then
// advance or jump; HALT is terminal until reset.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [0:15] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [0:15] o_pc,
    output logic        o_fetchReq,
    input  logic        i_fetchAck,
    input  logic [0:15] i_instr,
    output logic [0:15] o_instr,
    output logic        o_instrValid,
    input  logic        i_instrReady,
    input  logic        i_done,
    input  logic        i_jValid,
    input  logic        i_cond,
    input  logic [0:15] i_jTarget,
    input  logic        i_halt,
    output logic        o_halted,
    output logic [0:15] o_jumpCount
);

    state_t state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= FETCH;
            o_pc         <= RESET_PC;
            o_fetchReq   <= 1'b0;
            o_instr      <= 16'h0000;
            o_instrValid <= 1'b0;
            o_halted     <= 1'b0;
            o_jumpCount  <= 16'h0000;
        end else begin
            unique case (state)
                FETCH: begin
                    // request goes out one edge after reset release
                    o_fetchReq <= 1'b1;
                    if (o_fetchReq && i_fetchAck) begin
                        o_instr      <= i_instr;
                        o_fetchReq   <= 1'b0;
                        o_instrValid <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_instrReady) begin
                        o_instrValid <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (i_done) begin
                        if (i_halt) begin
                            o_halted <= 1'b1;
                            state    <= HALT;
                        end else begin
                            o_fetchReq <= 1'b1;
                            state      <= FETCH;
                            if (i_jValid && i_cond) begin
                                o_pc        <= i_jTarget;
                                o_jumpCount <= o_jumpCount + 16'd1;
                            end else begin
                                o_pc <= o_pc + 16'd1;
                            end
                        end
                    end
                end
                HALT: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a
// transaction-level model of the fetch/issue/exec/halt rules.
module tb_pc_sequencer;

    localparam logic [15:0] RST_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_en = 1'b0;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_pc         (bus.pc),
        .o_fetchReq   (bus.fetch_req),
        .i_fetchAck   (bus.fetch_ack),
        .i_instr      (bus.fetch_instr),
        .o_instr      (bus.instr),
        .o_instrValid (bus.instr_valid),
        .i_instrReady (bus.instr_ready),
        .i_done       (bus.done),
        .i_jValid     (bus.j_valid),
        .i_cond       (bus.cond),
        .i_jTarget    (bus.j_target),
        .i_halt       (bus.halt),
        .o_halted     (bus.halted),
        .o_jumpCount  (bus.jump_count)
    );

    always #5 clk = ~clk;

    // Model: phase 0 waiting for memory, 1 offering to decoder,
    // 2 executing, 3 stopped.
    int          m_ph;
    bit          m_fresh;
    logic [15:0] m_pc;
    logic [15:0] m_cnt;
    logic [15:0] m_instr;
    int          halt_cycles = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph    <= 0;
            m_fresh <= 1'b1;
            m_pc    <= RST_PC;
            m_cnt   <= 16'h0000;
            m_instr <= 16'h0000;
        end else begin
            m_fresh <= 1'b0;
            if (m_ph == 0 && !m_fresh && bus.fetch_ack) begin
                m_instr <= bus.fetch_instr;
                m_ph    <= 1;
            end else if (m_ph == 1 && bus.instr_ready) begin
                m_ph <= 2;
            end else if (m_ph == 2 && bus.done) begin
                if (bus.halt) begin
                    m_ph <= 3;
                end else if (bus.j_valid && bus.cond) begin
                    m_pc  <= bus.j_target;
                    m_cnt <= m_cnt + 16'd1;
                    m_ph  <= 0;
                end else begin
                    m_pc <= m_pc + 16'd1;
                    m_ph <= 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("pc", bus.pc, m_pc);
            chk("fetch_req", 16'(bus.fetch_req),
                16'(m_ph == 0 && !m_fresh));
            chk("instr_valid", 16'(bus.instr_valid), 16'(m_ph == 1));
            chk("instr", bus.instr, m_instr);
            chk("halted", 16'(bus.halted), 16'(m_ph == 3));
            chk("jump_count", bus.jump_count, m_cnt);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.fetch_ack   = 1'b0;
        bus.fetch_instr = 16'h0000;
        bus.instr_ready = 1'b0;
        bus.done        = 1'b0;
        bus.j_valid     = 1'b0;
        bus.cond        = 1'b0;
        bus.j_target    = 16'h0000;
        bus.halt        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_pc", bus.pc, RST_PC);
        chk("rst_valid", 16'(bus.instr_valid), 16'h0);
        chk("rst_instr", bus.instr, 16'h0000);
        chk("rst_halted", 16'(bus.halted), 16'h0);
        chk("rst_count", bus.jump_count, 16'h0000);
        chk("rst_req", 16'(bus.fetch_req), 16'h0);
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    // Caller is in fetch with the request visible; ends in exec.
    task automatic fetch_issue(input logic [15:0] w);
        bus.fetch_ack   = 1'b1;
        bus.fetch_instr = w;
        cyc();
        bus.fetch_ack   = 1'b0;
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;
    endtask

    task automatic complete(input bit jv, input bit c,
                            input logic [15:0] t, input bit h);
        bus.done     = 1'b1;
        bus.j_valid  = jv;
        bus.cond     = c;
        bus.j_target = t;
        bus.halt     = h;
        cyc();
        idle_inputs();
    endtask

    initial begin
        logic [15:0] held;
        idle_inputs();
        cyc();
        chk_en = 1'b1;
        do_reset();

        chk("boot_req", 16'(bus.fetch_req), 16'h1);
        chk("boot_pc", bus.pc, 16'h0000);
        bus.fetch_ack   = 1'b1;
        bus.fetch_instr = 16'hABCD;
        cyc();
        bus.fetch_ack = 1'b0;
        chk("boot_valid", 16'(bus.instr_valid), 16'h1);
        chk("boot_instr", bus.instr, 16'hABCD);
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;

        complete(1'b1, 1'b1, 16'h0040, 1'b0);
        chk("jump_pc", bus.pc, 16'h0040);
        chk("jump_cnt", bus.jump_count, 16'h0001);
        fetch_issue(16'h1111);
        complete(1'b1, 1'b0, 16'h0999, 1'b0);
        chk("nojump_pc", bus.pc, 16'h0041);
        chk("nojump_cnt", bus.jump_count, 16'h0001);

        fetch_issue(16'h2222);
        complete(1'b1, 1'b1, 16'hFFFF, 1'b0);
        chk("to_ffff", bus.pc, 16'hFFFF);
        fetch_issue(16'h3333);
        complete(1'b0, 1'b1, 16'h1234, 1'b0);
        chk("wrap_pc", bus.pc, 16'h0000);
        chk("wrap_cnt", bus.jump_count, 16'h0002);

        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_req", 16'(bus.fetch_req), 16'h1);
            chk("stall_pc", bus.pc, 16'h0000);
        end
        bus.fetch_ack   = 1'b1;
        bus.fetch_instr = 16'h5A5A;
        cyc();
        bus.fetch_ack   = 1'b0;
        bus.fetch_instr = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_instr", bus.instr, 16'h5A5A);
            chk("hold_valid", 16'(bus.instr_valid), 16'h1);
        end
        bus.instr_ready = 1'b1;
        cyc();
        bus.instr_ready = 1'b0;

        complete(1'b1, 1'b1, 16'h0777, 1'b1);
        chk("halt_flag", 16'(bus.halted), 16'h1);
        chk("halt_pc", bus.pc, 16'h0000);
        bus.fetch_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("halt_req", 16'(bus.fetch_req), 16'h0);
        end
        bus.fetch_ack = 1'b0;

        do_reset();
        bus.fetch_ack = 1'b1;
        bus.fetch_instr = 16'h0F0F;
        cyc();
        bus.fetch_ack = 1'b0;
        chk("pre_rst_valid", 16'(bus.instr_valid), 16'h1);
        do_reset();

        for (int n = 0; n < 4000; n++) begin
            bus.fetch_ack   = ($urandom_range(0, 1) == 1);
            bus.fetch_instr = 16'($urandom);
            bus.instr_ready = ($urandom_range(0, 1) == 1);
            bus.done        = ($urandom_range(0, 2) == 0);
            bus.j_valid     = ($urandom_range(0, 1) == 1);
            bus.cond        = ($urandom_range(0, 1) == 1);
            held            = 16'($urandom);
            bus.j_target    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : held;
            bus.halt        = ($urandom_range(0, 39) == 0);
            cyc();
            halt_cycles = (m_ph == 3) ? halt_cycles + 1 : 0;
            if (halt_cycles > 8 || $urandom_range(0, 299) == 0) begin
                idle_inputs();
                halt_cycles = 0;
                do_reset();
            end
        end

        idle_inputs();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
